kappa3_dbg_sequencer: RTL and testbench

//  Synthesizable debug-port sequencer for kappa3_light_core.
//  - Accepts a command stream (write PC/reg/mem, read reg/mem, register dump) and drives the core dbg_* ports.
//  - Returns read data as a response stream, so host/UART logic never toggles dbg strobes directly.
//  - Generalises the manual bench tasks: parametrised width, register count, memory bursts and settle delay.

---
 rtl/kappa3_dbg_sequencer.sv | 268 ++++++++++++++++++++++++++
 tb/tb_kappa3_dbg_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kappa3_dbg_sequencer.sv
// kappa3_dbg_sequencer
//   Debug-port sequencer for kappa3_light_core. Turns a command stream (write PC/reg/mem,
//   read reg/mem with bursts, register dump) into single-cycle dbg_* strobes on the core and
//   returns one response item per write, read, burst beat or dumped register.
//
//   Optional feature macro: KAPPA3_DBG_SEQ_STEP_EN
//     defined   : op 7 (STEP) pulses step_inst and waits for running to rise then fall,
//                 or for a 255-clock timeout (rsp_err=1 on timeout)
//     undefined : no step_inst port; op 7 answers with rsp_err=1
//
// Ports
//   clock, reset            rising-edge clock, synchronous active-low reset
//   cmd_valid/cmd_ready     command handshake; cmd_op/cmd_addr/cmd_data/cmd_len payload
//   rsp_valid/rsp_ready     response handshake; rsp_data/rsp_tag/rsp_err payload
//   dbg_in, dbg_*_ld, dbg_reg_addr, dbg_mem_addr, dbg_mem_read, dbg_mem_write  to core
//   dbg_reg_out, dbg_mem_out, running                                          from core
module kappa3_dbg_sequencer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned LEN_W  = 8,
    parameter int unsigned SETTLE = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [DATA_W-1:0] rsp_tag,
    output logic              rsp_err,
    output logic [DATA_W-1:0] dbg_in,
    output logic              dbg_pc_ld,
    output logic              dbg_reg_ld,
    output logic [REG_AW-1:0] dbg_reg_addr,
    output logic [DATA_W-1:0] dbg_mem_addr,
    output logic              dbg_mem_read,
    output logic              dbg_mem_write,
    input  logic [DATA_W-1:0] dbg_reg_out,
    input  logic [DATA_W-1:0] dbg_mem_out,
    input  logic              running
`ifdef KAPPA3_DBG_SEQ_STEP_EN
    ,
    output logic              step_inst
`endif
);

    localparam logic [2:0] OpNop   = 3'd0;
    localparam logic [2:0] OpWrPc  = 3'd1;
    localparam logic [2:0] OpWrReg = 3'd2;
    localparam logic [2:0] OpRdReg = 3'd3;
    localparam logic [2:0] OpWrMem = 3'd4;
    localparam logic [2:0] OpRdMem = 3'd5;
    localparam logic [2:0] OpDump  = 3'd6;
    localparam logic [2:0] OpStep  = 3'd7;

    localparam int unsigned SettleW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StStrobe,
        StSettle,
        StResp,
        StStepArm,
        StStepWait
    } state_e;

    state_e              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [DATA_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;      // burst items remaining, including the current one
    logic [SettleW-1:0]  settle_q, settle_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic [DATA_W-1:0]   rsp_tag_q, rsp_tag_d;
    logic                rsp_err_q, rsp_err_d;
`ifdef KAPPA3_DBG_SEQ_STEP_EN
    logic [7:0]          step_timer_q, step_timer_d;
    logic                step_seen_q, step_seen_d;
`else
    logic                unused_running;
    assign unused_running = running;
`endif

    // Register ops report the index, memory ops the byte address, everything else 0.
    function automatic logic [DATA_W-1:0] tag_of(input logic [2:0] op,
                                                  input logic [DATA_W-1:0] a);
        logic [DATA_W-1:0] t;
        t = '0;
        case (op)
            OpWrReg, OpRdReg, OpDump: t = DATA_W'(a[REG_AW-1:0]);
            OpWrMem, OpRdMem:         t = a;
            default:                  t = '0;
        endcase
        return t;
    endfunction

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        data_d     = data_q;
        cnt_d      = cnt_q;
        settle_d   = settle_q;
        rsp_data_d = rsp_data_q;
        rsp_tag_d  = rsp_tag_q;
        rsp_err_d  = rsp_err_q;
`ifdef KAPPA3_DBG_SEQ_STEP_EN
        step_timer_d = step_timer_q;
        step_seen_d  = step_seen_q;
`endif
        case (state_q)
            StIdle: begin
                if (cmd_valid && cmd_ready) begin
                    op_d   = cmd_op;
                    addr_d = cmd_addr;
                    data_d = cmd_data;
                    cnt_d  = (cmd_len == '0) ? LEN_W'(1) : cmd_len;
                    case (cmd_op)
                        OpNop: begin
                            state_d    = StResp;
                            rsp_data_d = '0;
                            rsp_tag_d  = '0;
                            rsp_err_d  = 1'b0;
                        end
                        OpDump: begin
                            addr_d  = '0;
                            state_d = StStrobe;
                        end
                        OpStep: begin
`ifdef KAPPA3_DBG_SEQ_STEP_EN
                            state_d = StStepArm;
`else
                            state_d    = StResp;
                            rsp_data_d = '0;
                            rsp_tag_d  = '0;
                            rsp_err_d  = 1'b1;
`endif
                        end
                        default: state_d = StStrobe;
                    endcase
                end
            end
            StStrobe: begin
                if (op_q == OpRdReg || op_q == OpRdMem || op_q == OpDump) begin
                    settle_d = SettleW'(SETTLE - 1);
                    state_d  = StSettle;
                end else begin
                    rsp_data_d = '0;
                    rsp_tag_d  = tag_of(op_q, addr_q);
                    rsp_err_d  = 1'b0;
                    state_d    = StResp;
                end
            end
            StSettle: begin
                if (settle_q == '0) begin
                    rsp_data_d = (op_q == OpRdMem) ? dbg_mem_out : dbg_reg_out;
                    rsp_tag_d  = tag_of(op_q, addr_q);
                    rsp_err_d  = 1'b0;
                    state_d    = StResp;
                end else begin
                    settle_d = settle_q - SettleW'(1);
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    if (op_q == OpRdMem && cnt_q > LEN_W'(1)) begin
                        cnt_d   = cnt_q - LEN_W'(1);
                        addr_d  = addr_q + DATA_W'(4);   // wraps modulo 2**DATA_W
                        state_d = StStrobe;
                    end else if (op_q == OpDump && addr_q[REG_AW-1:0] != '1) begin
                        addr_d  = addr_q + DATA_W'(1);
                        state_d = StStrobe;
                    end else begin
                        if (op_q == OpDump) begin
                            addr_d = '0;
                        end
                        cnt_d   = '0;
                        state_d = StIdle;
                    end
                end
            end
`ifdef KAPPA3_DBG_SEQ_STEP_EN
            StStepArm: begin
                step_timer_d = '0;
                step_seen_d  = 1'b0;
                state_d      = StStepWait;
            end
            StStepWait: begin
                step_timer_d = step_timer_q + 8'd1;
                if (running) begin
                    step_seen_d = 1'b1;
                end
                if (step_seen_q && !running) begin
                    rsp_data_d = '0;
                    rsp_tag_d  = '0;
                    rsp_err_d  = 1'b0;
                    state_d    = StResp;
                end else if (step_timer_q == 8'd254) begin
                    // 255th wait clock without a completed run pulse
                    rsp_data_d = '0;
                    rsp_tag_d  = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = StResp;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= StIdle;
            op_q       <= OpNop;
            addr_q     <= '0;
            data_q     <= '0;
            cnt_q      <= '0;
            settle_q   <= '0;
            rsp_data_q <= '0;
            rsp_tag_q  <= '0;
            rsp_err_q  <= 1'b0;
`ifdef KAPPA3_DBG_SEQ_STEP_EN
            step_timer_q <= '0;
            step_seen_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            cnt_q      <= cnt_d;
            settle_q   <= settle_d;
            rsp_data_q <= rsp_data_d;
            rsp_tag_q  <= rsp_tag_d;
            rsp_err_q  <= rsp_err_d;
`ifdef KAPPA3_DBG_SEQ_STEP_EN
            step_timer_q <= step_timer_d;
            step_seen_q  <= step_seen_d;
`endif
        end
    end

    // Gated with reset so nothing is accepted while reset is held.
    assign cmd_ready = (state_q == StIdle) && reset;

    assign rsp_valid = (state_q == StResp);
    assign rsp_data  = rsp_data_q;
    assign rsp_tag   = rsp_tag_q;
    assign rsp_err   = rsp_err_q;

    // Addresses stay stable through SETTLE so the core read data is valid at capture.
    assign dbg_in        = data_q;
    assign dbg_reg_addr  = addr_q[REG_AW-1:0];
    assign dbg_mem_addr  = addr_q;
    assign dbg_pc_ld     = (state_q == StStrobe) && (op_q == OpWrPc);
    assign dbg_reg_ld    = (state_q == StStrobe) && (op_q == OpWrReg);
    assign dbg_mem_write = (state_q == StStrobe) && (op_q == OpWrMem);
    assign dbg_mem_read  = (state_q == StStrobe) && (op_q == OpRdMem);
`ifdef KAPPA3_DBG_SEQ_STEP_EN
    assign step_inst     = (state_q == StStepArm);
`endif

endmodule

// File: tb/tb_kappa3_dbg_sequencer.sv
module tb_kappa3_dbg_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_data;
    logic [7:0]  cmd_len;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [31:0] rsp_tag;
    logic        rsp_err;
    logic [31:0] dbg_in;
    logic        dbg_pc_ld;
    logic        dbg_reg_ld;
    logic [4:0]  dbg_reg_addr;
    logic [31:0] dbg_mem_addr;
    logic        dbg_mem_read;
    logic        dbg_mem_write;
    logic [31:0] dbg_reg_out;
    logic [31:0] dbg_mem_out;
    logic        running;
`ifdef KAPPA3_DBG_SEQ_STEP_EN
    logic        step_inst;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    kappa3_dbg_sequencer #(
        .DATA_W(32),
        .REG_AW(5),
        .LEN_W (8),
        .SETTLE(1)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_addr     (cmd_addr),
        .cmd_data     (cmd_data),
        .cmd_len      (cmd_len),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_tag      (rsp_tag),
        .rsp_err      (rsp_err),
        .dbg_in       (dbg_in),
        .dbg_pc_ld    (dbg_pc_ld),
        .dbg_reg_ld   (dbg_reg_ld),
        .dbg_reg_addr (dbg_reg_addr),
        .dbg_mem_addr (dbg_mem_addr),
        .dbg_mem_read (dbg_mem_read),
        .dbg_mem_write(dbg_mem_write),
        .dbg_reg_out  (dbg_reg_out),
        .dbg_mem_out  (dbg_mem_out),
        .running      (running)
`ifdef KAPPA3_DBG_SEQ_STEP_EN
        ,
        .step_inst    (step_inst)
`endif
    );

    // Minimal core model: register file with x0 hardwired to 0, memory returns addr ^ A5A50000.
    logic [31:0] regs [32] = '{default: 32'h0};
    always @(posedge clock) begin
        if (dbg_reg_ld && dbg_reg_addr != 5'd0) regs[dbg_reg_addr] <= dbg_in;
    end
    assign dbg_reg_out = (dbg_reg_addr == 5'd0) ? 32'h0 : regs[dbg_reg_addr];
    assign dbg_mem_out = dbg_mem_addr ^ 32'hA5A5_0000;

    int pc_cnt = 0;
    int mem_rd_cnt = 0;
    always @(posedge clock) begin
        if (dbg_pc_ld) pc_cnt <= pc_cnt + 1;
        if (dbg_mem_read) mem_rd_cnt <= mem_rd_cnt + 1;
    end

    wire [3:0] strobes = {dbg_pc_ld, dbg_reg_ld, dbg_mem_read, dbg_mem_write};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clock);
    endtask

    // Present a command in the current cycle (T); returns at the negedge of T+1.
    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d,
                        input logic [7:0] len);
        cmd_op    = op;
        cmd_addr  = a;
        cmd_data  = d;
        cmd_len   = len;
        cmd_valid = 1'b1;
        chk("cmd_ready_at_issue", 32'(cmd_ready), 32'h1);
        nxt();
        cmd_valid = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        int idx;
        int n;
        logic [31:0] exp_tag [3];
        logic [31:0] exp_dat [3];

        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_addr  = 32'h0;
        cmd_data  = 32'h0;
        cmd_len   = 8'd0;
        rsp_ready = 1'b1;
        running   = 1'b0;

        // Reset state
        repeat (3) nxt();
        chk("rst_cmd_ready", 32'(cmd_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_strobes", 32'(strobes), 32'h0);
        chk("rst_rsp_data", rsp_data, 32'h0);
        chk("rst_rsp_tag", rsp_tag, 32'h0);
        chk("rst_rsp_err", 32'(rsp_err), 32'h0);
        reset = 1'b1;
        nxt();
        chk("rel_cmd_ready", 32'(cmd_ready), 32'h1);

        // WR_PC
        base = pc_cnt;
        send(3'd1, 32'h0, 32'h1000_0000, 8'd0);
        chk("wrpc_strobe", 32'(strobes), 32'b1000);
        chk("wrpc_dbg_in", dbg_in, 32'h1000_0000);
        chk("wrpc_rsp_early", 32'(rsp_valid), 32'h0);
        nxt();
        chk("wrpc_strobe_off", 32'(dbg_pc_ld), 32'h0);
        chk("wrpc_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("wrpc_rsp_data", rsp_data, 32'h0);
        chk("wrpc_rsp_err", 32'(rsp_err), 32'h0);
        nxt();
        chk("wrpc_idle_rsp", 32'(rsp_valid), 32'h0);
        chk("wrpc_idle_ready", 32'(cmd_ready), 32'h1);
        chk("wrpc_pulses", 32'(pc_cnt - base), 32'd1);

        // WR_REG x1
        send(3'd2, 32'h1, 32'h1234_5000, 8'd0);
        chk("wrreg_strobe", 32'(strobes), 32'b0100);
        chk("wrreg_addr", 32'(dbg_reg_addr), 32'd1);
        nxt();
        chk("wrreg_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("wrreg_rsp_tag", rsp_tag, 32'd1);
        nxt();

        // RD_REG x1, upper address bits ignored
        send(3'd3, 32'hFFFF_FFE1, 32'h0, 8'd0);
        chk("rdreg_addr", 32'(dbg_reg_addr), 32'd1);
        chk("rdreg_rsp_t1", 32'(rsp_valid), 32'h0);
        nxt();
        chk("rdreg_rsp_t2", 32'(rsp_valid), 32'h0);
        nxt();
        chk("rdreg_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("rdreg_rsp_data", rsp_data, 32'h1234_5000);
        chk("rdreg_rsp_tag", rsp_tag, 32'd1);
        chk("rdreg_rsp_err", 32'(rsp_err), 32'h0);
        nxt();

        // WR_MEM
        send(3'd4, 32'h0000_0100, 32'hCAFE_F00D, 8'd0);
        chk("wrmem_strobe", 32'(strobes), 32'b0001);
        chk("wrmem_addr", dbg_mem_addr, 32'h0000_0100);
        chk("wrmem_dbg_in", dbg_in, 32'hCAFE_F00D);
        nxt();
        chk("wrmem_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("wrmem_rsp_tag", rsp_tag, 32'h0000_0100);
        chk("wrmem_rsp_data", rsp_data, 32'h0);
        nxt();

        // RD_MEM burst of 3 across the address wrap, stall on item 0
        exp_tag[0] = 32'hFFFF_FFF8; exp_dat[0] = 32'h5A5A_FFF8;
        exp_tag[1] = 32'hFFFF_FFFC; exp_dat[1] = 32'h5A5A_FFFC;
        exp_tag[2] = 32'h0000_0000; exp_dat[2] = 32'hA5A5_0000;
        base = mem_rd_cnt;
        rsp_ready = 1'b0;
        send(3'd5, 32'hFFFF_FFF8, 32'h0, 8'd3);
        for (int k = 0; k < 3; k++) begin
            chk("rdmem_strobe", 32'(strobes), 32'b0010);
            chk("rdmem_addr", dbg_mem_addr, exp_tag[k]);
            nxt();
            chk("rdmem_settle_rsp", 32'(rsp_valid), 32'h0);
            nxt();
            chk("rdmem_rsp_valid", 32'(rsp_valid), 32'h1);
            chk("rdmem_rsp_tag", rsp_tag, exp_tag[k]);
            chk("rdmem_rsp_data", rsp_data, exp_dat[k]);
            if (k == 0) begin
                for (int s = 0; s < 4; s++) begin
                    nxt();
                    chk("rdmem_stall_valid", 32'(rsp_valid), 32'h1);
                    chk("rdmem_stall_tag", rsp_tag, exp_tag[0]);
                    chk("rdmem_stall_data", rsp_data, exp_dat[0]);
                    chk("rdmem_stall_strobe", 32'(dbg_mem_read), 32'h0);
                end
                rsp_ready = 1'b1;
            end
            nxt();
        end
        chk("rdmem_idle", 32'(cmd_ready), 32'h1);
        chk("rdmem_pulses", 32'(mem_rd_cnt - base), 32'd3);

        // NOP, with a second NOP offered while the first response is pending
        send(3'd0, 32'h0, 32'h0, 8'd0);
        chk("nop_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("nop_rsp_err", 32'(rsp_err), 32'h0);
        chk("nop_strobes", 32'(strobes), 32'h0);
        cmd_valid = 1'b1;
        chk("nop_busy_ready", 32'(cmd_ready), 32'h0);
        nxt();
        chk("nop2_ready", 32'(cmd_ready), 32'h1);
        chk("nop2_no_rsp", 32'(rsp_valid), 32'h0);
        nxt();
        cmd_valid = 1'b0;
        chk("nop2_rsp_valid", 32'(rsp_valid), 32'h1);
        nxt();

`ifdef KAPPA3_DBG_SEQ_STEP_EN
        // STEP with running held low times out
        send(3'd7, 32'h0, 32'h0, 8'd0);
        chk("step_pulse", 32'(step_inst), 32'h1);
        n = 1;
        while (!rsp_valid && n < 400) begin
            nxt();
            n++;
        end
        chk("step_latency", 32'(n), 32'd257);
        chk("step_rsp_err", 32'(rsp_err), 32'h1);
        chk("step_rsp_data", rsp_data, 32'h0);
        nxt();
`else
        // Op 7 unsupported
        send(3'd7, 32'h0, 32'h0, 8'd0);
        chk("step_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("step_rsp_err", 32'(rsp_err), 32'h1);
        chk("step_strobes", 32'(strobes), 32'h0);
        nxt();
        chk("step_idle", 32'(cmd_ready), 32'h1);
`endif

        // Full register dump
        send(3'd6, 32'h0, 32'h0, 8'd0);
        idx = 0;
        n = 0;
        while (idx < 32 && n < 200) begin
            if (rsp_valid) begin
                chk("dump_tag", rsp_tag, 32'(idx));
                chk("dump_data", rsp_data, (idx == 1) ? 32'h1234_5000 : 32'h0);
                idx++;
            end
            nxt();
            n++;
        end
        chk("dump_count", 32'(idx), 32'd32);
        chk("dump_idle", 32'(cmd_ready), 32'h1);
        chk("dump_idle_rsp", 32'(rsp_valid), 32'h0);

        // Reset held for 3 clocks in the middle of a dump
        send(3'd6, 32'h0, 32'h0, 8'd0);
        repeat (6) nxt();
        reset = 1'b0;
        repeat (3) begin
            nxt();
            chk("mid_rst_rsp", 32'(rsp_valid), 32'h0);
            chk("mid_rst_strobes", 32'(strobes), 32'h0);
            chk("mid_rst_ready", 32'(cmd_ready), 32'h0);
        end
        reset = 1'b1;
        nxt();
        chk("mid_rel_ready", 32'(cmd_ready), 32'h1);
        chk("mid_rel_idx", 32'(dbg_reg_addr), 32'h0);
        repeat (4) begin
            nxt();
            chk("mid_rel_no_rsp", 32'(rsp_valid), 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
